// File: rtl/shiftreg_pkg.sv
// rtl/shiftreg_pkg.sv - shared types and defaults for the tapped delay-line controller
// Purpose: state enum and default constants shared by shiftreg_tap_ctrl and
//          shiftreg_settle_timer.
// Contents: TAP_W_DEF (tap width), SETTLE_DEF (settle cycles), RST_BYPASS
//           (bypass reset value), state_e (controller states).
package shiftreg_pkg;

  localparam int   TAP_W_DEF  = 5;
  localparam int   SETTLE_DEF = 3;
  localparam logic RST_BYPASS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_SETTLE       = 2'd1,
    ST_SWEEP_DWELL  = 2'd2,
    ST_SWEEP_SETTLE = 2'd3
  } state_e;

endpackage

// File: rtl/shiftreg_settle_timer.sv
// rtl/shiftreg_settle_timer.sv - loadable down-counter that masks out_valid while delay lines settle
// Purpose: holds out_valid low for SETTLE cycles after every load, and after reset.
// Ports:
//   clk_i       - clock, rising edge
//   rst_n_i     - synchronous reset, active low (counter loads SETTLE)
//   load_i      - restart the settle window
//   expire_o    - high in the last masked cycle (out_valid rises on the next edge)
//   out_valid_o - delay lines are stable
module shiftreg_settle_timer
  import shiftreg_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  output logic expire_o,
  output logic out_valid_o
);

  localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A reload in the final masked cycle extends the window, so it is not an expiry.
  assign expire_o    = !load_i && (cnt_q == ONE);
  assign out_valid_o = (cnt_q == '0);

endmodule

// File: rtl/shiftreg_tap_ctrl.sv
// rtl/shiftreg_tap_ctrl.sv - shadow/active tap controller for a bank of tapped delay lines
// Purpose: host writes land in per-channel shadows; a frame_sync with pending
//          writes copies all shadows to the active taps at once and masks
//          out_valid for SETTLE cycles. Optional tap-sweep sequencer under
//          macro SHIFTREG_TAP_SWEEP_EN steps one channel through every tap.
// Ports:
//   clk_i, rst_n_i            - clock and synchronous active-low reset
//   wr_valid_i / wr_ready_o   - host write handshake
//   wr_ch_i, wr_tap_i, wr_bypass_i - write target channel and new settings
//   frame_sync_i              - frame-boundary strobe (commit point, dwell tick)
//   sweep_start_i, sweep_ch_i, sweep_dwell_i - sweep request, channel, frames per step
//   tap_o                     - active taps, channel c at [c*TAP_W +: TAP_W]
//   shiftBypass_o             - active bypass bits
//   out_valid_o               - delay-line outputs stable
//   sweep_busy_o, sweep_tap_o, sweep_done_o - sweep status
module shiftreg_tap_ctrl
  import shiftreg_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int TAP_W  = TAP_W_DEF,
  parameter  int SETTLE = SETTLE_DEF,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [CH_W-1:0]       wr_ch_i,
  input  logic [TAP_W-1:0]      wr_tap_i,
  input  logic                  wr_bypass_i,
  input  logic                  frame_sync_i,
  input  logic                  sweep_start_i,
  input  logic [CH_W-1:0]       sweep_ch_i,
  input  logic [7:0]            sweep_dwell_i,
  output logic [N_CH*TAP_W-1:0] tap_o,
  output logic [N_CH-1:0]       shiftBypass_o,
  output logic                  out_valid_o,
  output logic                  sweep_busy_o,
  output logic [TAP_W-1:0]      sweep_tap_o,
  output logic                  sweep_done_o
);

  state_e                  state_q;
  logic [N_CH*TAP_W-1:0]   sh_tap_q, act_tap_q;
  logic [N_CH-1:0]         sh_byp_q, act_byp_q;
  logic                    dirty_q;

  logic idle_like, wr_fire, apply, sweep_go, tmr_load, tmr_expire;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_SETTLE);
  assign wr_fire   = wr_valid_i && wr_ready_o;

`ifdef SHIFTREG_TAP_SWEEP_EN
  logic [CH_W-1:0]  sw_ch_q;
  logic [7:0]       dwell_q, frame_cnt_q;
  logic [TAP_W-1:0] sweep_tap_q;
  logic             sweep_done_q;
  logic             dwell_hit, at_max;

  // A start outranks a coincident apply; the pending shadows wait for the sweep to end.
  assign sweep_go  = sweep_start_i && idle_like;
  assign dwell_hit = (state_q == ST_SWEEP_DWELL) && frame_sync_i &&
                     ((frame_cnt_q + 8'd1) == dwell_q);
  assign at_max    = &sweep_tap_q;
  assign tmr_load  = apply || sweep_go || dwell_hit;

  assign wr_ready_o   = idle_like;
  assign sweep_busy_o = !idle_like;
  assign sweep_tap_o  = sweep_tap_q;
  assign sweep_done_o = sweep_done_q;
`else
  logic unused_sweep;
  assign unused_sweep = ^{sweep_start_i, sweep_ch_i, sweep_dwell_i};

  assign sweep_go     = 1'b0;
  assign tmr_load     = apply;
  assign wr_ready_o   = 1'b1;
  assign sweep_busy_o = 1'b0;
  assign sweep_tap_o  = '0;
  assign sweep_done_o = 1'b0;
`endif

  assign apply = frame_sync_i && dirty_q && idle_like && !sweep_go;

  shiftreg_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .load_i      (tmr_load),
    .expire_o    (tmr_expire),
    .out_valid_o (out_valid_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      sh_tap_q  <= '0;
      act_tap_q <= '0;
      sh_byp_q  <= {N_CH{RST_BYPASS}};
      act_byp_q <= {N_CH{RST_BYPASS}};
      dirty_q   <= 1'b0;
`ifdef SHIFTREG_TAP_SWEEP_EN
      sw_ch_q      <= '0;
      dwell_q      <= 8'd1;
      frame_cnt_q  <= '0;
      sweep_tap_q  <= '0;
      sweep_done_q <= 1'b0;
`endif
    end else begin
`ifdef SHIFTREG_TAP_SWEEP_EN
      sweep_done_q <= 1'b0;
`endif
      // The apply copies the pre-edge shadows, so a same-cycle write waits for the next frame.
      if (wr_fire) begin
        sh_tap_q[wr_ch_i*TAP_W +: TAP_W] <= wr_tap_i;
        sh_byp_q[wr_ch_i]                <= wr_bypass_i;
      end
      if (wr_fire) begin
        dirty_q <= 1'b1;
      end else if (apply) begin
        dirty_q <= 1'b0;
      end
      if (apply) begin
        act_tap_q <= sh_tap_q;
        act_byp_q <= sh_byp_q;
      end

      case (state_q)
        ST_IDLE, ST_SETTLE: begin
`ifdef SHIFTREG_TAP_SWEEP_EN
          if (sweep_go) begin
            sw_ch_q      <= sweep_ch_i;
            dwell_q      <= (sweep_dwell_i == 8'd0) ? 8'd1 : sweep_dwell_i;
            frame_cnt_q  <= '0;
            sweep_tap_q  <= '0;
            act_tap_q[sweep_ch_i*TAP_W +: TAP_W] <= '0;
            act_byp_q[sweep_ch_i]                <= 1'b0;
            state_q      <= ST_SWEEP_SETTLE;
          end else
`endif
          if (apply) begin
            state_q <= ST_SETTLE;
          end else if ((state_q == ST_SETTLE) && tmr_expire) begin
            state_q <= ST_IDLE;
          end
        end
`ifdef SHIFTREG_TAP_SWEEP_EN
        ST_SWEEP_SETTLE: begin
          // Leave on the edge where out_valid rises, so no frame is missed.
          if (tmr_expire) begin
            frame_cnt_q <= '0;
            state_q     <= ST_SWEEP_DWELL;
          end
        end
        ST_SWEEP_DWELL: begin
          if (dwell_hit) begin
            frame_cnt_q <= '0;
            if (at_max) begin
              act_tap_q[sw_ch_q*TAP_W +: TAP_W] <= sh_tap_q[sw_ch_q*TAP_W +: TAP_W];
              act_byp_q[sw_ch_q]                <= sh_byp_q[sw_ch_q];
              sweep_tap_q  <= '0;
              sweep_done_q <= 1'b1;
              state_q      <= ST_SETTLE;
            end else begin
              sweep_tap_q <= sweep_tap_q + TAP_W'(1);
              act_tap_q[sw_ch_q*TAP_W +: TAP_W] <= sweep_tap_q + TAP_W'(1);
              state_q     <= ST_SWEEP_SETTLE;
            end
          end else if (frame_sync_i) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tap_o         = act_tap_q;
  assign shiftBypass_o = act_byp_q;

endmodule

// File: tb/tb_shiftreg_tap_ctrl.sv
// tb/tb_shiftreg_tap_ctrl.sv - self-checking bench for shiftreg_tap_ctrl (sweep part under SHIFTREG_TAP_SWEEP_EN)
module tb_shiftreg_tap_ctrl;

  localparam int N_CH   = 4;
  localparam int TAP_W  = 5;
  localparam int SETTLE = 3;
`ifdef SHIFTREG_TAP_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, wr_valid, wr_bypass, frame_sync, sweep_start;
  logic [1:0]  wr_ch, sweep_ch;
  logic [4:0]  wr_tap;
  logic [7:0]  sweep_dwell;
  logic        wr_ready, out_valid, sweep_busy, sweep_done;
  logic [19:0] tap;
  logic [3:0]  shiftBypass;
  logic [4:0]  sweep_tap;

  always #5 clk = ~clk;

  shiftreg_tap_ctrl #(
    .N_CH   (N_CH),
    .TAP_W  (TAP_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_ch_i       (wr_ch),
    .wr_tap_i      (wr_tap),
    .wr_bypass_i   (wr_bypass),
    .frame_sync_i  (frame_sync),
    .sweep_start_i (sweep_start),
    .sweep_ch_i    (sweep_ch),
    .sweep_dwell_i (sweep_dwell),
    .tap_o         (tap),
    .shiftBypass_o (shiftBypass),
    .out_valid_o   (out_valid),
    .sweep_busy_o  (sweep_busy),
    .sweep_tap_o   (sweep_tap),
    .sweep_done_o  (sweep_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: per-channel settings as plain ints, settle window as a count of masked cycles left.
  int m_tap[N_CH], m_byp[N_CH], s_tap[N_CH], s_byp[N_CH];
  int m_left, m_ch, m_stap, m_dwell, m_frames;
  bit m_dirty, m_sw, m_done;
  bit model_on = 1'b0;

  always @(posedge clk) begin
    bit acc;
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        m_tap[c] = 0; m_byp[c] = 1; s_tap[c] = 0; s_byp[c] = 1;
      end
      m_dirty = 0; m_sw = 0; m_done = 0; m_left = SETTLE;
      m_stap = 0; m_frames = 0; m_ch = 0; m_dwell = 1;
    end else begin
      acc    = wr_valid && !m_sw;
      m_done = 0;
      if (SWEEP && sweep_start && !m_sw) begin
        m_sw = 1; m_ch = int'(sweep_ch);
        m_dwell = (sweep_dwell == 0) ? 1 : int'(sweep_dwell);
        m_stap = 0; m_frames = 0;
        m_tap[m_ch] = 0; m_byp[m_ch] = 0;
        m_left = SETTLE;
      end else if (m_sw) begin
        if (m_left > 0) begin
          m_left--;
        end else if (frame_sync) begin
          m_frames++;
          if (m_frames >= m_dwell) begin
            m_frames = 0;
            if (m_stap == (1 << TAP_W) - 1) begin
              m_tap[m_ch] = s_tap[m_ch]; m_byp[m_ch] = s_byp[m_ch];
              m_sw = 0; m_done = 1; m_stap = 0;
            end else begin
              m_stap++;
              m_tap[m_ch] = m_stap;
            end
            m_left = SETTLE;
          end
        end
      end else begin
        if (frame_sync && m_dirty) begin
          for (int c = 0; c < N_CH; c++) begin
            m_tap[c] = s_tap[c]; m_byp[c] = s_byp[c];
          end
          m_dirty = 0;
          m_left  = SETTLE;
        end else if (m_left > 0) begin
          m_left--;
        end
      end
      if (acc) begin
        s_tap[wr_ch] = int'(wr_tap); s_byp[wr_ch] = int'(wr_bypass);
        m_dirty = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [19:0] et;
    logic [3:0]  eb;
    if (model_on) begin
      et = '0; eb = '0;
      for (int c = 0; c < N_CH; c++) begin
        et[c*TAP_W +: TAP_W] = TAP_W'(m_tap[c]);
        eb[c]                = m_byp[c][0];
      end
      chk("m_tap", tap, et);
      chk("m_bypass", shiftBypass, eb);
      chk("m_out_valid", out_valid, m_left == 0);
      chk("m_wr_ready", wr_ready, !m_sw);
      chk("m_sweep_busy", sweep_busy, m_sw);
      chk("m_sweep_tap", sweep_tap, m_stap);
      chk("m_sweep_done", sweep_done, m_done);
    end
  end

  initial begin
    int cyc, dones, steps;
    logic [4:0] prev;
    rst_n = 0; wr_valid = 0; wr_bypass = 0; frame_sync = 0; sweep_start = 0;
    wr_ch = 0; sweep_ch = 0; wr_tap = 0; sweep_dwell = 0;
    @(posedge clk);
    model_on = 1'b1;
    #1;
    repeat (2) tick();
    rst_n = 1;

    // Reset release: out_valid rises on the third edge.
    tick(); @(negedge clk);
    chk("rst_tap", tap, 20'h0);
    chk("rst_bypass", shiftBypass, 4'hF);
    chk("rst_ov1", out_valid, 0);
    chk("rst_wr_ready", wr_ready, 1);
    tick(); @(negedge clk); chk("rst_ov2", out_valid, 0);
    tick(); @(negedge clk); chk("rst_ov3", out_valid, 1);

    // Write ch2, apply 10 cycles later.
    wr_valid = 1; wr_ch = 2; wr_tap = 7; wr_bypass = 0;
    tick(); wr_valid = 0;
    @(negedge clk); chk("write_no_effect", tap, 20'h0);
    repeat (9) tick();
    frame_sync = 1; tick(); frame_sync = 0;
    @(negedge clk);
    chk("apply_ch2_tap", tap[14:10], 7);
    chk("apply_bypass", shiftBypass, 4'hB);
    chk("apply_ov0", out_valid, 0);
    tick(); @(negedge clk); chk("apply_ov1", out_valid, 0);
    tick(); @(negedge clk); chk("apply_ov2", out_valid, 0);
    tick(); @(negedge clk); chk("apply_ov3", out_valid, 1);

    // Write coincident with frame_sync is held to the next frame.
    wr_valid = 1; wr_ch = 1; wr_tap = 5; wr_bypass = 1; frame_sync = 1;
    tick(); wr_valid = 0; frame_sync = 0;
    @(negedge clk);
    chk("coinc_not_applied", tap[9:5], 0);
    chk("coinc_ov", out_valid, 1);
    repeat (3) tick();
    frame_sync = 1; tick(); frame_sync = 0;
    @(negedge clk); chk("coinc_next_frame", tap[9:5], 5);

    // Last write wins, then a second apply during settle restarts the window.
    wr_valid = 1; wr_ch = 3; wr_tap = 9; wr_bypass = 0; tick();
    wr_tap = 12; wr_bypass = 1; tick(); wr_valid = 0;
    frame_sync = 1; tick(); frame_sync = 0;
    @(negedge clk);
    chk("last_write_wins", tap[19:15], 12);
    chk("last_write_bypass", shiftBypass, 4'hB);
    wr_valid = 1; wr_ch = 0; wr_tap = 3; wr_bypass = 1; tick(); wr_valid = 0;
    frame_sync = 1; tick(); frame_sync = 0;
    @(negedge clk);
    chk("restart_tap0", tap[4:0], 3);
    chk("restart_ov0", out_valid, 0);
    tick(); @(negedge clk); chk("restart_ov1", out_valid, 0);
    tick(); @(negedge clk); chk("restart_ov2", out_valid, 0);
    tick(); @(negedge clk); chk("restart_ov3", out_valid, 1);
    frame_sync = 1; tick(); frame_sync = 0;
    @(negedge clk); chk("clean_frame_ov", out_valid, 1);

`ifdef SHIFTREG_TAP_SWEEP_EN
    // Pending ch3 write, then sweep ch0 started on a frame_sync.
    wr_valid = 1; wr_ch = 3; wr_tap = 20; wr_bypass = 0; tick(); wr_valid = 0;
    sweep_start = 1; sweep_ch = 0; sweep_dwell = 2; frame_sync = 1;
    tick(); sweep_start = 0; frame_sync = 0;
    @(negedge clk);
    chk("sw_busy", sweep_busy, 1);
    chk("sw_wr_ready", wr_ready, 0);
    chk("sw_tap0", tap[4:0], 0);
    chk("sw_byp0", shiftBypass[0], 0);
    chk("sw_apply_deferred", tap[19:15], 12);
    cyc = 0; dones = 0; steps = 0; prev = 0;
    while (cyc < 3000) begin
      frame_sync  = (cyc % 6 == 5);
      wr_valid    = (cyc == 10); wr_ch = 1; wr_tap = 31; wr_bypass = 0;
      sweep_start = (cyc == 20); sweep_ch = 1;
      tick();
      @(negedge clk);
      if (sweep_done) dones++;
      if (sweep_busy && sweep_tap != prev) steps++;
      prev = sweep_tap;
      if (!sweep_busy) break;
      cyc++;
    end
    frame_sync = 0; wr_valid = 0; sweep_start = 0;
    chk("sw_timeout", cyc < 3000, 1);
    chk("sw_steps", steps, 31);
    repeat (5) begin
      tick(); @(negedge clk);
      if (sweep_done) dones++;
    end
    chk("sw_done_once", dones, 1);
    chk("sw_restore_tap0", tap[4:0], 3);
    chk("sw_bypass_after", shiftBypass, 4'hB);
    chk("sw_ch3_still_old", tap[19:15], 12);
    frame_sync = 1; tick(); frame_sync = 0;
    @(negedge clk);
    chk("sw_deferred_apply", tap[19:15], 20);
    chk("sw_rejected_write", tap[9:5], 5);
    chk("sw_deferred_byp", shiftBypass, 4'h3);

    // Reset in the middle of a sweep (dwell 0 behaves as 1).
    repeat (4) tick();
    sweep_start = 1; sweep_ch = 1; sweep_dwell = 0; tick(); sweep_start = 0;
    cyc = 0;
    while (cyc < 2000) begin
      frame_sync = (cyc % 4 == 3);
      tick(); @(negedge clk);
      if (sweep_tap == 5'd12) break;
      cyc++;
    end
    chk("rst_sw_timeout", cyc < 2000, 1);
    frame_sync = 0; rst_n = 0; tick(); rst_n = 1;
    @(negedge clk);
    chk("rst_sw_tap", tap, 20'h0);
    chk("rst_sw_byp", shiftBypass, 4'hF);
    chk("rst_sw_busy", sweep_busy, 0);
    chk("rst_sw_done", sweep_done, 0);
    repeat (6) tick();
`else
    // Sweep inputs are ignored: the coincident apply proceeds.
    wr_valid = 1; wr_ch = 0; wr_tap = 17; wr_bypass = 0; tick(); wr_valid = 0;
    sweep_start = 1; sweep_ch = 0; sweep_dwell = 2; frame_sync = 1;
    tick(); sweep_start = 0; frame_sync = 0;
    @(negedge clk);
    chk("nosw_apply", tap[4:0], 17);
    chk("nosw_byp", shiftBypass, 4'hA);
    chk("nosw_busy", sweep_busy, 0);
    chk("nosw_wr_ready", wr_ready, 1);
    repeat (6) tick();
`endif

    @(negedge clk);
    model_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
